// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : serial_subtractor
//  Purpose  : Bit-serial subtractor. It computes d = a - b - bin LSB first,
//             using one full-subtractor cell per clock over WIDTH cycles.
//             Operands arrive on a valid/ready handshake, and results leave
//             on a valid/ready handshake.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1      rising-edge clock
//    rst_n      in   1      synchronous, active-low reset
//    in_valid   in   1      a, b and bin are valid this cycle
//    in_ready   out  1      block can accept an operand set (IDLE)
//    a          in   WIDTH  minuend
//    b          in   WIDTH  subtrahend
//    bin        in   1      borrow-in
//    out_valid  out  1      d, bout and ovf are valid (DONE)
//    out_ready  in   1      consumer accepts the result
//    d          out  WIDTH  difference a - b - bin, mod 2^WIDTH
//    bout       out  1      borrow-out (a < b + bin, unsigned)
//    ovf        out  1      two's-complement overflow of a - b - bin
// ============================================================================
module serial_subtractor #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] d,
   output logic             bout,
   output logic             ovf
);

   localparam int               c_CNT_W = $clog2(WIDTH);
   localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

   localparam logic [1:0] c_IDLE = 2'd0;
   localparam logic [1:0] c_RUN  = 2'd1;
   localparam logic [1:0] c_DONE = 2'd2;

   logic [1:0]         r_state;
   logic [1:0]         w_state_nxt;

   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_b;
   logic               r_brw;
   logic [c_CNT_W-1:0] r_cnt;
   // Partial result. It holds the WIDTH-1 bits already computed. The
   // final bit is merged directly into the output register.
   logic [WIDTH-2:0]   r_sh;
   logic [WIDTH-1:0]   r_d;
   logic               r_bout;
   logic               r_ovf;

   logic               w_ai;
   logic               w_bi;
   logic               w_di;
   logic               w_brw_nxt;
   logic [WIDTH-1:0]   w_cat;

   // ---------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= c_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ---------------------------------------------------------------------
   // FSM: next-state logic
   // ---------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_IDLE:  if (in_valid)          w_state_nxt = c_RUN;
         c_RUN:   if (r_cnt == c_LAST)   w_state_nxt = c_DONE;
         c_DONE:  if (out_ready)         w_state_nxt = c_IDLE;
         default:                        w_state_nxt = c_IDLE;
      endcase
   end

   // ---------------------------------------------------------------------
   // FSM: outputs (decoded from registered state only)
   // ---------------------------------------------------------------------
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (r_state)
         c_IDLE:  in_ready  = 1'b1;
         c_DONE:  out_valid = 1'b1;
         default: ;
      endcase
   end

   // ---------------------------------------------------------------------
   // Full-subtractor cell for the current bit
   // ---------------------------------------------------------------------
   assign w_ai      = r_a[r_cnt];
   assign w_bi      = r_b[r_cnt];
   assign w_di      = w_ai ^ w_bi ^ r_brw;
   assign w_brw_nxt = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_brw);

   // The new bit enters at the MSB end. After the last bit, this value is
   // the complete difference.
   assign w_cat     = {w_di, r_sh};

   // ---------------------------------------------------------------------
   // Datapath
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_a    <= '0;
         r_b    <= '0;
         r_brw  <= 1'b0;
         r_cnt  <= '0;
         r_sh   <= '0;
         r_d    <= '0;
         r_bout <= 1'b0;
         r_ovf  <= 1'b0;
      end else begin
         case (r_state)
            c_IDLE: begin
               if (in_valid) begin
                  r_a   <= a;
                  r_b   <= b;
                  r_brw <= bin;
                  r_cnt <= '0;
                  r_sh  <= '0;
               end
            end
            c_RUN: begin
               r_brw <= w_brw_nxt;
               r_sh  <= w_cat[WIDTH-1:1];
               if (r_cnt == c_LAST) begin
                  // The result is published only here, so it stays
                  // stable in DONE and after DONE until the next op ends.
                  r_d    <= w_cat;
                  r_bout <= w_brw_nxt;
                  r_ovf  <= (r_a[WIDTH-1] ^ r_b[WIDTH-1]) & (w_di ^ r_a[WIDTH-1]);
               end else begin
                  r_cnt <= r_cnt + c_CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign d    = r_d;
   assign bout = r_bout;
   assign ovf  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_subtractor
//  Purpose  : Directed self-checking bench for serial_subtractor (WIDTH=4).
//  Revision : 1.0  initial release
// ============================================================================
module tb_serial_subtractor;

   localparam int WIDTH = 4;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] d;
   logic             bout;
   logic             ovf;

   int n_vec = 0;
   int n_err = 0;

   serial_subtractor #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .bin       (bin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .d         (d),
      .bout      (bout),
      .ovf       (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (observed=running, expected=finished)");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: unsigned borrow from a 5-bit difference, overflow from
   // true signed arithmetic range.
   function automatic logic [5:0] model(input logic [3:0] x, input logic [3:0] y,
                                        input logic c);
      logic [4:0] df;
      int         s;
      df = {1'b0, x} - {1'b0, y} - {4'b0, c};
      s  = int'($signed(x)) - int'($signed(y)) - int'(c);
      return {((s < -8) || (s > 7)), df[4], df[3:0]};
   endfunction

   // Sends one operand set, waits for the result, and checks latency and value.
   // The inputs are scrambled right after acceptance to show that the latched
   // operands are immune to later input changes.
   task automatic run_op(input logic [3:0] ta, input logic [3:0] tbv, input logic tbin,
                         input logic [3:0] ed, input logic eb, input logic eo,
                         input string tag, input bit consume);
      int lat;
      chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      a = ta; b = tbv; bin = tbin; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; a = ~ta; b = ~tbv; bin = ~tbin;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      chk({tag, "_latency"}, 32'(lat), 32'd4);
      chk({tag, "_d"},    32'(d),    32'(ed));
      chk({tag, "_bout"}, 32'(bout), 32'(eb));
      chk({tag, "_ovf"},  32'(ovf),  32'(eo));
      if (consume) begin
         out_ready = 1'b1;
         @(posedge clk); #1;
         out_ready = 1'b0;
         chk({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
         chk({tag, "_ready_back"}, 32'(in_ready),  32'd1);
         chk({tag, "_d_kept"},     32'(d),         32'(ed));
      end
   endtask

   initial begin
      logic [3:0] rv_a [16];
      logic [3:0] rv_b [16];
      logic       rv_c [16];
      logic [5:0] m;
      int idx_in, idx_out, cyc, last_acc;
      bit acc;

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; bin = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Reset state
      chk("rst_in_ready",  32'(in_ready),  32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_d",         32'(d),         32'd0);
      chk("rst_bout",      32'(bout),      32'd0);
      chk("rst_ovf",       32'(ovf),       32'd0);

      // Basic vectors
      run_op(4'd7, 4'd3, 1'b0, 4'd4,  1'b0, 1'b0, "t1_7m3",  1);
      run_op(4'd3, 4'd7, 1'b0, 4'd12, 1'b1, 1'b0, "t2_3m7",  1);
      run_op(4'd8, 4'd1, 1'b0, 4'd7,  1'b0, 1'b1, "t3_8m1",  1);
      run_op(4'd0, 4'd0, 1'b1, 4'd15, 1'b1, 1'b0, "t3_0m0b", 1);

      // Backpressure: the result is held, and a pulsed request is ignored
      run_op(4'd9, 4'd2, 1'b1, 4'd6, 1'b0, 1'b1, "t4_bp", 0);
      for (int i = 0; i < 5; i++) begin
         if (i == 1) begin
            in_valid = 1'b1; a = 4'd1; b = 4'd1; bin = 1'b0;
         end else begin
            in_valid = 1'b0;
         end
         @(posedge clk); #1;
         chk("t4_hold_valid", 32'(out_valid), 32'd1);
         chk("t4_hold_d",     32'(d),         32'd6);
         chk("t4_hold_bout",  32'(bout),      32'd0);
         chk("t4_hold_ready", 32'(in_ready),  32'd0);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("t4_release_valid", 32'(out_valid), 32'd0);
      chk("t4_release_ready", 32'(in_ready),  32'd1);
      chk("t4_release_d",     32'(d),         32'd6);
      chk("t4_release_ovf",   32'(ovf),       32'd1);
      repeat (6) @(posedge clk);
      #1 chk("t4_no_ghost_op", 32'(out_valid), 32'd0);

      // Reset during the 2nd RUN cycle
      chk("t5_in_ready", 32'(in_ready), 32'd1);
      a = 4'd7; b = 4'd3; bin = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("t5_valid", 32'(out_valid), 32'd0);
      chk("t5_d",     32'(d),         32'd0);
      chk("t5_ovf",   32'(ovf),       32'd0);
      chk("t5_ready", 32'(in_ready),  32'd1);
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         chk("t5_no_partial", 32'(out_valid), 32'd0);
      end
      run_op(4'd5, 4'd2, 1'b0, 4'd3, 1'b0, 1'b0, "t5_fresh", 1);

      // Back-to-back with random operands
      for (int i = 0; i < 16; i++) begin
         rv_a[i] = 4'($urandom_range(0, 15));
         rv_b[i] = 4'($urandom_range(0, 15));
         rv_c[i] = 1'($urandom_range(0, 1));
      end
      idx_in = 0; idx_out = 0; cyc = 0; last_acc = -1;
      a = rv_a[0]; b = rv_b[0]; bin = rv_c[0];
      in_valid = 1'b1; out_ready = 1'b1;
      while (idx_out < 16 && cyc < 400) begin
         if (out_valid) begin
            m = model(rv_a[idx_out], rv_b[idx_out], rv_c[idx_out]);
            chk($sformatf("t6_d[%0d]", idx_out),    32'(d),    32'(m[3:0]));
            chk($sformatf("t6_bout[%0d]", idx_out), 32'(bout), 32'(m[4]));
            chk($sformatf("t6_ovf[%0d]", idx_out),  32'(ovf),  32'(m[5]));
            idx_out++;
         end
         acc = in_ready && in_valid && (idx_in < 16);
         if (acc) begin
            if (last_acc >= 0)
               chk($sformatf("t6_spacing[%0d]", idx_in), 32'(cyc - last_acc), 32'd6);
            last_acc = cyc;
            idx_in++;
         end
         @(posedge clk); #1;
         cyc++;
         if (acc) begin
            if (idx_in < 16) begin
               a = rv_a[idx_in]; b = rv_b[idx_in]; bin = rv_c[idx_in];
            end else begin
               in_valid = 1'b0;
            end
         end
      end
      in_valid = 1'b0; out_ready = 1'b0;
      chk("t6_results_seen", 32'(idx_out), 32'd16);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
